// File: rtl/sdr_init_refresh_ctrl_if.sv
// Command-bus and refresh-handshake bundle between the init/refresh sequencer and its neighbours.
// master: the sequencer driving SDRAM pins; slave: arbiter/config side.
interface sdr_init_refresh_ctrl_if;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;

    logic [ADDR_W-1:0] cfg_mode_reg;
    logic              cfg_refresh_en;
    logic              ref_gnt;
    logic              ref_req;
    logic              cmd_own;
    logic              sdr_cke;
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [ADDR_W-1:0] sdr_addr;
    logic [BA_W-1:0]   sdr_ba;
    logic              sdr_init_done;
    logic              ref_miss;

    modport master (
        input  cfg_mode_reg, cfg_refresh_en, ref_gnt,
        output ref_req, cmd_own, sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
               sdr_addr, sdr_ba, sdr_init_done, ref_miss
    );

    modport slave (
        output cfg_mode_reg, cfg_refresh_en, ref_gnt,
        input  ref_req, cmd_own, sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
               sdr_addr, sdr_ba, sdr_init_done, ref_miss
    );
endinterface

// File: rtl/sdr_init_refresh_ctrl.sv
// SDRAM power-up init sequencer and periodic auto-refresh scheduler with req/gnt bus hand-off.
// Define SDR_REF_BACKLOG_EN to queue up to 7 refreshes and issue them all under one grant.
module sdr_init_refresh_ctrl #(
    parameter int unsigned INIT_WAIT      = 500,
    parameter int unsigned TRP            = 2,
    parameter int unsigned TRFC           = 7,
    parameter int unsigned INIT_REFRESH   = 2,
    parameter int unsigned TMRD           = 2,
    parameter int unsigned REFRESH_PERIOD = 780
) (
    input  logic                    sdram_clk,
    input  logic                    sdram_resetn,
    sdr_init_refresh_ctrl_if.master bus
);
    localparam int unsigned MAX_WAIT = (INIT_WAIT > REFRESH_PERIOD) ? INIT_WAIT : REFRESH_PERIOD;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int unsigned AREF_W   = $clog2(INIT_REFRESH + 1);
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned CMD_W    = 4;
`ifdef SDR_REF_BACKLOG_EN
    localparam int unsigned PEND_W   = 3;
`else
    localparam int unsigned PEND_W   = 1;
`endif

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0]  CMD_NOP      = 4'b1111;
    localparam logic [CMD_W-1:0]  CMD_PRE      = 4'b0010;
    localparam logic [CMD_W-1:0]  CMD_AREF     = 4'b0001;
    localparam logic [CMD_W-1:0]  CMD_LMR      = 4'b0000;
    localparam logic [ADDR_W-1:0] PRE_ALL_ADDR = 13'h0400;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_PRE, S_TRP_WAIT, S_AREF, S_TRFC_WAIT, S_LMR, S_TMRD_WAIT,
        S_IDLE, S_R_PRE, S_R_TRP, S_R_AREF, S_R_TRFC
    } state_t;

    state_t              state, state_next_c;
    logic [CNT_W-1:0]    wcnt, rcnt;
    logic [AREF_W-1:0]   init_aref;
    logic [PEND_W-1:0]   pend, pend_next_c;
    logic                wait_done_c, ref_run_c, expire_c, dec_c, miss_c;
    logic [CMD_W-1:0]    cmd_c;
    logic [ADDR_W-1:0]   addr_c;

    assign wait_done_c = (wcnt == '0);

    // Next-state selection; outputs below are registered from the state being entered.
    always_comb begin
        state_next_c = state;
        case (state)
            S_INIT_WAIT: if (bus.sdr_cke && wait_done_c) state_next_c = S_PRE;
            S_PRE:       state_next_c = S_TRP_WAIT;
            S_TRP_WAIT:  if (wait_done_c) state_next_c = S_AREF;
            S_AREF:      state_next_c = S_TRFC_WAIT;
            S_TRFC_WAIT: if (wait_done_c)
                             state_next_c = (init_aref == AREF_W'(INIT_REFRESH)) ? S_LMR : S_AREF;
            S_LMR:       state_next_c = S_TMRD_WAIT;
            S_TMRD_WAIT: if (wait_done_c) state_next_c = S_IDLE;
            S_IDLE:      if (bus.ref_req && bus.ref_gnt) state_next_c = S_R_PRE;
            S_R_PRE:     state_next_c = S_R_TRP;
            S_R_TRP:     if (wait_done_c) state_next_c = S_R_AREF;
            S_R_AREF:    state_next_c = S_R_TRFC;
            S_R_TRFC: begin
                if (wait_done_c) begin
`ifdef SDR_REF_BACKLOG_EN
                    state_next_c = (pend != '0) ? S_R_AREF : S_IDLE;
`else
                    state_next_c = S_IDLE;
`endif
                end
            end
            default:     state_next_c = S_INIT_WAIT;
        endcase
    end

    // Refresh period tracking and pending bookkeeping.
    always_comb begin
        ref_run_c   = bus.cfg_refresh_en &&
                      (state inside {S_IDLE, S_R_PRE, S_R_TRP, S_R_AREF, S_R_TRFC});
        expire_c    = ref_run_c && (rcnt == CNT_W'(REFRESH_PERIOD - 1));
        dec_c       = (state_next_c == S_R_AREF);
        pend_next_c = pend;
        miss_c      = 1'b0;
`ifdef SDR_REF_BACKLOG_EN
        if (expire_c && !dec_c) begin
            if (pend != '1) pend_next_c = pend + PEND_W'(1);
        end else if (dec_c && !expire_c) begin
            pend_next_c = pend - PEND_W'(1);
        end
`else
        if (expire_c && !dec_c) begin
            miss_c      = pend[0];
            pend_next_c = 1'b1;
        end else if (dec_c && !expire_c) begin
            pend_next_c = 1'b0;
        end
`endif
    end

    always_comb begin
        cmd_c  = CMD_NOP;
        addr_c = '0;
        case (state_next_c)
            S_PRE, S_R_PRE: begin
                cmd_c  = CMD_PRE;
                addr_c = PRE_ALL_ADDR;
            end
            S_AREF, S_R_AREF: cmd_c = CMD_AREF;
            S_LMR: begin
                cmd_c  = CMD_LMR;
                addr_c = bus.cfg_mode_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state             <= S_INIT_WAIT;
            wcnt              <= '0;
            rcnt              <= '0;
            init_aref         <= '0;
            pend              <= '0;
            bus.sdr_cke       <= 1'b0;
            {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= CMD_NOP;
            bus.sdr_addr      <= '0;
            bus.sdr_ba        <= '0;
            bus.sdr_init_done <= 1'b0;
            bus.ref_req       <= 1'b0;
            bus.cmd_own       <= 1'b1;
            bus.ref_miss      <= 1'b0;
        end else begin
            state <= state_next_c;
            pend  <= pend_next_c;

            // cke low doubles as "INIT_WAIT not yet started"
            if (state == S_INIT_WAIT && !bus.sdr_cke) begin
                wcnt <= CNT_W'(INIT_WAIT - 1);
            end else if (state_next_c != state) begin
                case (state_next_c)
                    S_TRP_WAIT, S_R_TRP:   wcnt <= CNT_W'(TRP - 1);
                    S_TRFC_WAIT, S_R_TRFC: wcnt <= CNT_W'(TRFC - 1);
                    S_TMRD_WAIT:           wcnt <= CNT_W'(TMRD - 1);
                    default:               wcnt <= '0;
                endcase
            end else if (!wait_done_c) begin
                wcnt <= wcnt - CNT_W'(1);
            end

            if (state == S_TMRD_WAIT && state_next_c == S_IDLE) begin
                rcnt <= '0;
            end else if (ref_run_c) begin
                rcnt <= expire_c ? '0 : rcnt + CNT_W'(1);
            end

            if (state_next_c == S_AREF && state != S_AREF) begin
                init_aref <= init_aref + AREF_W'(1);
            end

            bus.sdr_cke       <= 1'b1;
            {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= cmd_c;
            bus.sdr_addr      <= addr_c;
            bus.sdr_ba        <= '0;
            bus.sdr_init_done <= bus.sdr_init_done || (state_next_c == S_IDLE);
            bus.cmd_own       <= (state_next_c != S_IDLE);
            bus.ref_req       <= (state_next_c == S_IDLE) && (pend_next_c != '0);
            bus.ref_miss      <= miss_c;
        end
    end
endmodule

// File: tb/tb_sdr_init_refresh_ctrl.sv
// Scoreboard bench for sdr_init_refresh_ctrl: stimulus queues expected commands and status
// checkpoints; a negedge monitor pops and compares them as the DUT presents them.
module tb_sdr_init_refresh_ctrl;
    localparam int unsigned INIT_WAIT      = 10;
    localparam int unsigned TRP            = 2;
    localparam int unsigned TRFC           = 7;
    localparam int unsigned INIT_REFRESH   = 2;
    localparam int unsigned TMRD           = 2;
    localparam int unsigned REFRESH_PERIOD = 50;
    localparam logic [12:0] MODE = 13'h033;

    localparam logic [3:0] C_NOP  = 4'b1111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;

    // status word {cke, cs_n, ras_n, cas_n, we_n, init_done, ref_req, cmd_own, ref_miss}
    localparam logic [8:0] M_CKE  = 9'h100;
    localparam logic [8:0] M_CMD  = 9'h0F0;
    localparam logic [8:0] M_DONE = 9'h008;
    localparam logic [8:0] M_REQ  = 9'h004;
    localparam logic [8:0] M_OWN  = 9'h002;
    localparam logic [8:0] M_MISS = 9'h001;
    localparam logic [8:0] M_ALL  = 9'h1FF;

    typedef struct {
        int          phase;
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
        string       name;
    } cmd_exp_t;

    typedef struct {
        int          phase;
        int          cyc;
        logic [8:0]  mask;
        logic [8:0]  val;
        string       name;
    } st_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   phase;
    bit   finish_req = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    cmd_exp_t cmd_q[$];
    st_exp_t  st_q[$];

    always #5 clk = ~clk;

    sdr_init_refresh_ctrl_if bus();

    sdr_init_refresh_ctrl #(
        .INIT_WAIT      (INIT_WAIT),
        .TRP            (TRP),
        .TRFC           (TRFC),
        .INIT_REFRESH   (INIT_REFRESH),
        .TMRD           (TMRD),
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) dut (
        .sdram_clk    (clk),
        .sdram_resetn (rst_n),
        .bus          (bus)
    );

    // cycle n = n-th rising edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [8:0] sv(input logic cke, input logic [3:0] c, input logic d,
                                      input logic q, input logic o, input logic m);
        return {cke, c, d, q, o, m};
    endfunction

    task automatic exp_st(input int p, input int c, input logic [8:0] m, input logic [8:0] v,
                          input string n);
        st_exp_t e;
        e.phase = p; e.cyc = c; e.mask = m; e.val = v; e.name = n;
        st_q.push_back(e);
    endtask

    task automatic exp_cmd(input int p, input int c, input logic [3:0] k, input logic [12:0] a,
                           input string n);
        cmd_exp_t e;
        e.phase = p; e.cyc = c; e.cmd = k; e.addr = a; e.name = n;
        cmd_q.push_back(e);
    endtask

    task automatic plan_init(input int p, input bit full);
        exp_st(p, 0, M_ALL, sv(1'b0, C_NOP, 1'b0, 1'b0, 1'b1, 1'b0), "reset_state");
        exp_st(p, 1, M_CKE | M_CMD | M_DONE | M_OWN | M_REQ,
               sv(1'b1, C_NOP, 1'b0, 1'b0, 1'b1, 1'b0), "first_edge");
        exp_cmd(p, 11, C_PRE, 13'h0400, "init_pre_all");
        exp_cmd(p, 14, C_AREF, 13'h0000, "init_aref1");
        if (full) begin
            exp_cmd(p, 22, C_AREF, 13'h0000, "init_aref2");
            exp_cmd(p, 30, C_LMR, MODE, "init_lmr");
            exp_st(p, 32, M_DONE | M_OWN, sv(1'b1, C_NOP, 1'b0, 1'b0, 1'b1, 1'b0), "before_done");
            exp_st(p, 33, M_DONE | M_OWN | M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0),
                   "init_done");
        end else begin
            exp_st(p, 19, M_CKE | M_DONE | M_OWN, sv(1'b1, C_NOP, 1'b0, 1'b0, 1'b1, 1'b0),
                   "mid_trfc");
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 50000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic next_phase(input int p);
        #1;
        rst_n = 1'b0;
        phase = p;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: command scoreboard, NOP address check, and status checkpoints.
    always @(negedge clk) begin
        logic [8:0] got;
        cmd_exp_t   ce;
        st_exp_t    se;
        got = {bus.sdr_cke, bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n,
               bus.sdr_init_done, bus.ref_req, bus.cmd_own, bus.ref_miss};

        if (got[7:4] == C_NOP) begin
            vectors++;
            if (bus.sdr_addr != 13'h0 || bus.sdr_ba != 2'h0) begin
                miscompares++;
                $display("FAIL nop_addr phase %0d cyc %0d: addr %h ba %h, expected 0", phase, cyc,
                         bus.sdr_addr, bus.sdr_ba);
            end
        end else if (rst_n) begin
            vectors++;
            if (cmd_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_cmd phase %0d cyc %0d: cmd %b addr %h, expected none",
                         phase, cyc, got[7:4], bus.sdr_addr);
            end else begin
                ce = cmd_q.pop_front();
                if (ce.phase != phase || ce.cyc != cyc || ce.cmd != got[7:4] ||
                    ce.addr != bus.sdr_addr || bus.sdr_ba != 2'h0) begin
                    miscompares++;
                    $display("FAIL %s: got phase %0d cyc %0d cmd %b addr %h ba %h, expected phase %0d cyc %0d cmd %b addr %h ba 0",
                             ce.name, phase, cyc, got[7:4], bus.sdr_addr, bus.sdr_ba,
                             ce.phase, ce.cyc, ce.cmd, ce.addr);
                end
            end
        end

        while (st_q.size() > 0 &&
               (st_q[0].phase < phase || (st_q[0].phase == phase && st_q[0].cyc < cyc))) begin
            se = st_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: checkpoint phase %0d cyc %0d skipped, now phase %0d cyc %0d",
                     se.name, se.phase, se.cyc, phase, cyc);
        end
        while (st_q.size() > 0 && st_q[0].phase == phase && st_q[0].cyc == cyc) begin
            se = st_q.pop_front();
            vectors++;
            if ((got & se.mask) != (se.val & se.mask)) begin
                miscompares++;
                $display("FAIL %s phase %0d cyc %0d: status %b, expected %b (mask %b)",
                         se.name, phase, cyc, got & se.mask, se.val & se.mask, se.mask);
            end
        end

        if (finish_req) begin
            vectors++;
            if (cmd_q.size() != 0) begin
                miscompares++;
                $display("FAIL cmd_drain: %0d expected commands never seen, expected 0",
                         cmd_q.size());
            end
            vectors++;
            if (st_q.size() != 0) begin
                miscompares++;
                $display("FAIL status_drain: %0d checkpoints unvisited, expected 0", st_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.cfg_mode_reg   = MODE;
        bus.cfg_refresh_en = 1'b1;
        bus.ref_gnt        = 1'b0;
        phase              = 1;

        // Phase 1: init, ignored grant, first refresh handshake
        plan_init(1, 1'b1);
        exp_st(1, 41, M_OWN | M_REQ | M_CMD, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "ignored_gnt");
        exp_st(1, 82, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "req_before_period");
        exp_st(1, 83, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "req_rise");
        exp_st(1, 85, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "req_held");
        exp_st(1, 86, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b1, 1'b0), "gnt_taken");
        exp_st(1, 96, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b1, 1'b0), "last_trfc");
        exp_st(1, 97, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "bus_released");
        exp_st(1, 132, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "req_second_before");
        exp_st(1, 133, M_REQ | M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "req_second");
        exp_cmd(1, 86, C_PRE, 13'h0400, "ref_pre");
        exp_cmd(1, 89, C_AREF, 13'h0000, "ref_aref");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_cyc(40);  bus.ref_gnt = 1'b1;
        wait_cyc(41);  bus.ref_gnt = 1'b0;
        wait_cyc(85);  bus.ref_gnt = 1'b1;
        wait_cyc(86);  bus.ref_gnt = 1'b0;
        wait_cyc(135);

        // Phase 2: grant withheld for 120 cycles after first request
        plan_init(2, 1'b1);
        exp_st(2, 83, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "bl_req_rise");
`ifdef SDR_REF_BACKLOG_EN
        exp_st(2, 133, M_REQ | M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "bl_no_miss1");
        exp_st(2, 183, M_REQ | M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "bl_no_miss2");
`else
        exp_st(2, 132, M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "miss_before");
        exp_st(2, 133, M_REQ | M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b1), "miss_pulse1");
        exp_st(2, 134, M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "miss_end1");
        exp_st(2, 183, M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b1), "miss_pulse2");
        exp_st(2, 184, M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "miss_end2");
`endif
        exp_st(2, 203, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "bl_req_wait");
        exp_st(2, 204, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b1, 1'b0), "bl_gnt_taken");
        exp_cmd(2, 204, C_PRE, 13'h0400, "bl_pre");
        exp_cmd(2, 207, C_AREF, 13'h0000, "bl_aref1");
`ifdef SDR_REF_BACKLOG_EN
        exp_cmd(2, 215, C_AREF, 13'h0000, "bl_aref2");
        exp_cmd(2, 223, C_AREF, 13'h0000, "bl_aref3");
        exp_st(2, 214, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b1, 1'b0), "bl_burst_own1");
        exp_st(2, 230, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b1, 1'b0), "bl_burst_own2");
        exp_st(2, 231, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "bl_released");
        exp_st(2, 233, M_REQ | M_MISS, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "bl_next_req");
`else
        exp_st(2, 214, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b1, 1'b0), "single_own");
        exp_st(2, 215, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "single_released");
        exp_st(2, 232, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "single_no_req");
        exp_st(2, 233, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "single_next_req");
        exp_st(2, 252, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "single2_released");
        exp_cmd(2, 241, C_PRE, 13'h0400, "single2_pre");
        exp_cmd(2, 244, C_AREF, 13'h0000, "single2_aref");
`endif
        next_phase(2);
        wait_cyc(203); bus.ref_gnt = 1'b1;
        wait_cyc(204); bus.ref_gnt = 1'b0;
`ifdef SDR_REF_BACKLOG_EN
        wait_cyc(236);
`else
        wait_cyc(240); bus.ref_gnt = 1'b1;
        wait_cyc(241); bus.ref_gnt = 1'b0;
        wait_cyc(256);
`endif

        // Phase 3 aborted by reset at cycle 20; phase 4 repeats the full init
        plan_init(3, 1'b0);
        next_phase(3);
        wait_cyc(20);
        plan_init(4, 1'b1);
        next_phase(4);
        wait_cyc(40);

        // Phase 5: refresh counting frozen between cycles 60 and 100
        plan_init(5, 1'b1);
        exp_st(5, 83, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "frozen_no_req83");
        exp_st(5, 100, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "frozen_no_req100");
        exp_st(5, 122, M_REQ, sv(1'b1, C_NOP, 1'b1, 1'b0, 1'b0, 1'b0), "delayed_before");
        exp_st(5, 123, M_REQ | M_OWN, sv(1'b1, C_NOP, 1'b1, 1'b1, 1'b0, 1'b0), "delayed_req");
        next_phase(5);
        wait_cyc(60);  bus.cfg_refresh_en = 1'b0;
        wait_cyc(100); bus.cfg_refresh_en = 1'b1;
        wait_cyc(125);

        finish_req = 1'b1;
    end
endmodule

// File: doc/sdr_init_refresh_ctrl.md
# sdr_init_refresh_ctrl

SDRAM command sequencer that owns the SDRAM command bus from reset until the memory is initialized, then schedules periodic auto-refresh. It sits between the Wishbone-facing request path and the SDRAM pins, alongside the read/write command path. Refresh ownership is traded with the main command arbiter through a req/gnt handshake. It drives `sdr_init_done` to release the rest of the controller.

## Interface
Parameters:
- `INIT_WAIT`, 500 — NOP cycles after reset release before PRECHARGE ALL
- `TRP`, 2 — NOP cycles after PRECHARGE
- `TRFC`, 7 — NOP cycles after each AUTO REFRESH
- `INIT_REFRESH`, 2 — AUTO REFRESH commands during init (≥1)
- `TMRD`, 2 — NOP cycles after LOAD MODE REGISTER
- `REFRESH_PERIOD`, 780 — cycles between refresh requests

Ports:
- `sdram_clk` in 1 — SDRAM clock; all logic on rising edge
- `sdram_resetn` in 1 — asynchronous active-low reset
- `cfg_mode_reg` in 13 — value driven on `sdr_addr` during LOAD MODE REGISTER
- `cfg_refresh_en` in 1 — enables periodic refresh counting
- `ref_gnt` in 1 — arbiter grant; bus free for one refresh sequence
- `ref_req` out 1 — refresh pending, requesting bus
- `cmd_own` out 1 — this block drives the command bus
- `sdr_cke` out 1, `sdr_cs_n` `sdr_ras_n` `sdr_cas_n` `sdr_we_n` out 1 each — SDRAM command
- `sdr_addr` out 13, `sdr_ba` out 2 — address/bank during commands
- `sdr_init_done` out 1 — init complete, sticky until reset
- `ref_miss` out 1 — one-cycle pulse, refresh period lost (macro off only)

## Operation
- Commands (cs,ras,cas,we): NOP 1111, PRECHARGE 0010 with `sdr_addr[10]`=1, AUTO REFRESH 0001, LMR 0000. Outside commands: NOP, addr/ba 0.
- Init FSM: INIT_WAIT → PRE → TRP_WAIT → AREF → TRFC_WAIT (loop to AREF until INIT_REFRESH issued) → LMR (addr=`cfg_mode_reg`, ba=0) → TMRD_WAIT → IDLE.
- `sdr_cke`=1 from the first edge after reset release.
- Entering IDLE: `sdr_init_done`=1, `cmd_own`=0, refresh counter cleared.
- Refresh counter runs in IDLE and during refresh sequences while `cfg_refresh_en`=1. At REFRESH_PERIOD−1 it wraps to 0 and increments pending. Disabling freezes the counter; it does not clear it.
- `ref_req` = pending≠0 and state IDLE.
- Grant sequence: `ref_gnt` sampled high with `ref_req`=1 → R_PRE → R_TRP → R_AREF → R_TRFC → IDLE, with pending decremented at R_AREF.
- `cmd_own` is 1 from R_PRE through the last R_TRFC cycle.
- `ref_gnt` while `ref_req`=0 is ignored.
- Counter width is `$clog2(max(INIT_WAIT,REFRESH_PERIOD)+1)`. Every wait counter loads N−1 and counts down to 0.

## Timing
- Reset (async, immediate): `sdr_cke`=0, command NOP, addr/ba=0, `sdr_init_done`=0, `ref_req`=0, `cmd_own`=1, `ref_miss`=0, counters and pending=0, state INIT_WAIT.
- Reset mid-sequence aborts it; init restarts from INIT_WAIT.
- Cycle n is the n-th rising edge after deassertion; outputs are registered.
- Init latency: `sdr_init_done` rises at cycle INIT_WAIT+1+TRP+INIT_REFRESH·(1+TRFC)+1+TMRD+1.
- Grant latency: PRECHARGE appears the cycle after `ref_gnt` is sampled.
- `ref_req` falls in the same cycle `cmd_own` rises.
- A single-cycle `ref_gnt` suffices.
- Refresh sequence length: 1+TRP+1+TRFC cycles.
- Period expiry in the grant cycle or during a sequence adds to pending. `ref_req` reasserts on return to IDLE.

## Configuration
- `SDR_REF_BACKLOG_EN` defined: pending is a 3-bit counter saturating at 7. One grant issues all pending AUTO REFRESHes back-to-back: one PRECHARGE, then (AREF, TRFC NOPs) repeated until pending=0. `ref_miss` is tied 0.
- Undefined: pending is one bit. Expiry while already pending pulses `ref_miss` for one cycle and the period is lost. One AREF per grant.

## Test plan
Bench parameters: INIT_WAIT=10, TRP=2, TRFC=7, INIT_REFRESH=2, TMRD=2, REFRESH_PERIOD=50, `cfg_mode_reg`=0x033.
- Release reset → NOP cycles 1–10, PRE@11, AREF@14 and @22, LMR@30 with addr=0x033, `sdr_init_done`=1 and `cmd_own`=0 @33.
- Idle with `cfg_refresh_en`=1 → `ref_req` rises @83. Pulse `ref_gnt` one cycle → `ref_req`=0 and PRE next cycle, AREF 3 cycles later, `cmd_own`=0 after 7 TRFC NOPs.
- Hold `ref_gnt`=0 for 120 cycles after first request:
  - macro off → `ref_miss` pulses @133, then one AREF per grant;
  - macro on → pending=3, one grant gives PRE + 3 AREFs spaced 8 cycles.
- Assert `sdram_resetn`=0 at cycle 20 (mid-TRFC) → all outputs to reset values same cycle; after release the full init repeats, `sdr_init_done` @33.
- `cfg_refresh_en`=0 from cycle 60 to 100 → no `ref_req` in that window; request occurs 40 cycles later than nominal.
- `ref_gnt`=1 while `ref_req`=0 → no command issued, `cmd_own` stays 0.
